// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that time-shares one registered datapath stage (active-low EN bank)
// among NREQ requesters. Each grant runs SETUP -> WRITE -> DONE so D is stable for a full
// cycle before and after the load edge; ACK pulses for one cycle in DONE.
module reg_write_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                  CK,
    input  logic                  CLR,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*WIDTH-1:0] DIN,
    output logic [NREQ-1:0]       GNT,
    output logic                  ACK,
    output logic                  BUSY,
    output logic [WIDTH-1:0]      REG_D,
    output logic                  REG_EN
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StWrite = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              ack_q, ack_d;
    logic [WIDTH-1:0]  regd_q, regd_d;
    logic              regen_q, regen_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     sel_q, sel_d;

    logic              found_hi, found_lo;
    logic [PW-1:0]     pick_hi, pick_lo, pick;
    logic [WIDTH-1:0]  pick_data;
    logic              req_sel;

    // Round-robin pick: lowest request at or above ptr, else lowest overall; X/Z counts as idle
    always_comb begin
        found_hi  = 1'b0;
        found_lo  = 1'b0;
        pick_hi   = '0;
        pick_lo   = '0;
        pick_data = '0;
        req_sel   = 1'b0;
        // Descending scan so the last hit is the lowest index
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (REQ[j] === 1'b1) begin
                found_lo = 1'b1;
                pick_lo  = PW'(j);
                if (PW'(j) >= ptr_q) begin
                    found_hi = 1'b1;
                    pick_hi  = PW'(j);
                end
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
        for (int j = 0; j < NREQ; j++) begin
            if (PW'(j) == pick) begin
                pick_data = DIN[j*WIDTH +: WIDTH];
            end
            if (PW'(j) == sel_q) begin
                req_sel = (REQ[j] === 1'b1);
            end
        end
    end

    // Next-state and registered-output logic for the SETUP/WRITE/DONE sequence
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = ack_q;
        regd_d  = regd_q;
        regen_d = regen_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        unique case (state_q)
            StIdle: begin
                if (found_lo) begin
                    state_d = StSetup;
                    gnt_d   = NREQ'(1) << pick;
                    regd_d  = pick_data;
                    sel_d   = pick;
                end
            end
            StSetup: begin
                if (!req_sel) begin
                    // Requester withdrew before the load: abandon, keep priority where it was
                    state_d = StIdle;
                    gnt_d   = '0;
                    regd_d  = '0;
                end else begin
                    state_d = StWrite;
                    regen_d = 1'b0;
                end
            end
            StWrite: begin
                state_d = StDone;
                regen_d = 1'b1;
                ack_d   = 1'b1;
            end
            StDone: begin
                state_d = StIdle;
                ack_d   = 1'b0;
                gnt_d   = '0;
                regd_d  = '0;
                ptr_d   = (sel_q == PW'(NREQ - 1)) ? '0 : sel_q + PW'(1);
            end
        endcase
    end

    // State register; CLR is shared with the bank so an in-flight write is simply dropped
    always_ff @(posedge CK or negedge CLR) begin
        if (!CLR) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ack_q   <= 1'b0;
            regd_q  <= '0;
            regen_q <= 1'b1;
            ptr_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            regd_q  <= regd_d;
            regen_q <= regen_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end

    assign GNT    = gnt_q;
    assign ACK    = ack_q;
    assign BUSY   = (state_q != StIdle);
    assign REG_D  = regd_q;
    assign REG_EN = regen_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: a transaction-level driver predicts each grant from
// the round-robin rule and fixed 4-cycle service timing; a monitor compares every cycle.
module tb_reg_write_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int MAXE  = 2048;

    logic                  CK;
    logic                  CLR;
    logic [NREQ-1:0]       REQ;
    logic [NREQ*WIDTH-1:0] DIN;
    logic [NREQ-1:0]       GNT;
    logic                  ACK;
    logic                  BUSY;
    logic [WIDTH-1:0]      REG_D;
    logic                  REG_EN;

    reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .CK     (CK),
        .CLR    (CLR),
        .REQ    (REQ),
        .DIN    (DIN),
        .GNT    (GNT),
        .ACK    (ACK),
        .BUSY   (BUSY),
        .REG_D  (REG_D),
        .REG_EN (REG_EN)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // The shared register bank this block drives
    logic [WIDTH-1:0] bank_q;
    always @(posedge CK or negedge CLR) begin
        if (!CLR) bank_q <= '0;
        else if (!REG_EN) bank_q <= REG_D;
    end

    int ecount = 0;
    always @(posedge CK) ecount <= ecount + 1;

    // Expected outputs after each edge, plus committed data awaiting ACK
    logic [NREQ-1:0]  exp_gnt    [MAXE];
    logic [WIDTH-1:0] exp_regd   [MAXE];
    logic             exp_busy   [MAXE];
    logic             exp_en_low [MAXE];
    logic             exp_ack    [MAXE];
    logic [WIDTH-1:0] sb[$];

    int total = 0;
    int bad   = 0;
    int mptr  = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string nm, input int n, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @edge %0d: got %0h want %0h", nm, n, act, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = (p + i) % NREQ;
            if (r[idx] === 1'b1) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NREQ*WIDTH-1:0] rand_din();
        logic [NREQ*WIDTH-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        return v;
    endfunction

    // Monitor: compare every cycle against the per-edge expectations
    always @(negedge CK) begin
        if (mon_en && ecount > 0 && ecount <= MAXE) begin
            int n;
            n = ecount - 1;
            chk("gnt", n, 64'(GNT), 64'(exp_gnt[n]));
            chk("busy", n, 64'(BUSY), 64'(exp_busy[n]));
            chk("reg_d", n, 64'(REG_D), 64'(exp_regd[n]));
            chk("reg_en", n, 64'(REG_EN), 64'(!exp_en_low[n]));
            chk("ack", n, 64'(ACK), 64'(exp_ack[n]));
            if (ACK === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ack_unexpected @edge %0d: got ACK=1 want no pending write", n);
                end else begin
                    logic [WIDTH-1:0] want;
                    want = sb.pop_front();
                    chk("bank_q", n, 64'(bank_q), 64'(want));
                end
            end
        end
    end

    // One request episode starting at the upcoming edge e. mode: 0 hold inputs, 1 randomise
    // other REQ bits and DIN while busy, 2 change DIN after grant and drop REQ during WRITE.
    task automatic run_txn(input logic [NREQ-1:0] req, input logic [NREQ*WIDTH-1:0] din,
                           input bit abort, input int mode);
        int e, g;
        logic [WIDTH-1:0] data;
        e = ecount;
        if (req == '0 || e + 4 >= MAXE) begin
            REQ = '0;
            DIN = din;
            @(negedge CK);
            return;
        end
        REQ = req;
        DIN = din;
        g = pick(req, mptr);
        data = din[g*WIDTH +: WIDTH];
        exp_busy[e] = 1'b1;
        exp_gnt[e]  = NREQ'(1) << g;
        exp_regd[e] = data;
        @(negedge CK);
        if (abort) begin
            REQ = '0;
            DIN = rand_din();
            @(negedge CK);
            return;
        end
        for (int k = 1; k <= 2; k++) begin
            exp_busy[e+k] = 1'b1;
            exp_gnt[e+k]  = NREQ'(1) << g;
            exp_regd[e+k] = data;
        end
        exp_en_low[e+1] = 1'b1;
        exp_ack[e+2]    = 1'b1;
        sb.push_back(data);
        mptr = (g + 1) % NREQ;
        if (mode == 1) begin
            REQ = NREQ'($urandom) | (NREQ'(1) << g);
            DIN = rand_din();
        end else if (mode == 2) begin
            DIN = ~din;
        end
        @(negedge CK);
        if (mode == 1) begin
            REQ = NREQ'($urandom);
            DIN = rand_din();
        end else if (mode == 2) begin
            REQ = '0;
        end
        @(negedge CK);
        if (mode == 1) begin
            REQ = NREQ'($urandom);
            DIN = rand_din();
        end
        @(negedge CK);
    endtask

    initial begin
        logic [NREQ*WIDTH-1:0] d;
        for (int i = 0; i < MAXE; i++) begin
            exp_gnt[i] = '0; exp_regd[i] = '0; exp_busy[i] = 1'b0;
            exp_en_low[i] = 1'b0; exp_ack[i] = 1'b0;
        end
        CLR = 1'b0;
        REQ = '0;
        DIN = '0;
        repeat (2) @(negedge CK);
        chk("rst_gnt", ecount, 64'(GNT), 64'(0));
        chk("rst_ack", ecount, 64'(ACK), 64'(0));
        chk("rst_busy", ecount, 64'(BUSY), 64'(0));
        chk("rst_reg_d", ecount, 64'(REG_D), 64'(0));
        chk("rst_reg_en", ecount, 64'(REG_EN), 64'(1));
        CLR = 1'b1;
        @(negedge CK);

        // Asynchronous clear in the middle of a WRITE
        REQ = 4'b0001;
        DIN = '0;
        DIN[0 +: WIDTH] = 8'h5A;
        @(negedge CK);
        @(negedge CK);
        chk("mid_reg_en", ecount, 64'(REG_EN), 64'(0));
        chk("mid_gnt", ecount, 64'(GNT), 64'(1));
        #2 CLR = 1'b0;
        #1;
        chk("clr_gnt", ecount, 64'(GNT), 64'(0));
        chk("clr_reg_en", ecount, 64'(REG_EN), 64'(1));
        chk("clr_ack", ecount, 64'(ACK), 64'(0));
        chk("clr_reg_d", ecount, 64'(REG_D), 64'(0));
        chk("clr_busy", ecount, 64'(BUSY), 64'(0));
        chk("clr_bank", ecount, 64'(bank_q), 64'(0));
        REQ = '0;
        @(negedge CK);
        CLR = 1'b1;
        @(negedge CK);
        mptr = 0;
        mon_en = 1'b1;

        // Round robin with every request held
        for (int i = 0; i < NREQ; i++) d[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
        for (int t = 0; t < 5; t++) run_txn(4'b1111, d, 1'b0, 0);
        run_txn('0, '0, 1'b0, 0);

        // Abort in SETUP must leave the priority pointer alone
        run_txn(4'b0010, rand_din(), 1'b1, 0);
        run_txn(4'b0011, rand_din(), 1'b0, 0);
        run_txn('0, '0, 1'b0, 0);

        // Single write of A5 from requester 2
        d = rand_din();
        d[2*WIDTH +: WIDTH] = 8'hA5;
        run_txn(4'b0100, d, 1'b0, 0);

        // DIN change after grant and REQ drop during WRITE
        d = rand_din();
        d[0 +: WIDTH] = 8'h11;
        run_txn(4'b0001, d, 1'b0, 2);

        // Random traffic
        for (int t = 0; t < 250; t++) begin
            logic [NREQ-1:0] r;
            r = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
            run_txn(r, rand_din(), ($urandom_range(0, 4) == 0), int'($urandom_range(0, 2)));
        end

        REQ = '0;
        repeat (4) @(negedge CK);
        chk("sb_drained", ecount, 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
